// File: rtl/fft_ring_node_if.sv
// Handshake bundle for one FFT ring stop: upstream/downstream ring links,
// local injection port, local ejection port and the two event pulses.
interface fft_ring_node_if #(
    parameter int ID_W      = 8,
    parameter int PT_W      = 32,
    parameter int NUM_NODES = 8
);
    localparam int HOP_W = $clog2(NUM_NODES + 1);
    localparam int MSG_W = 2 * ID_W + PT_W + 1 + HOP_W;

    logic             ring_in_valid;
    logic             ring_in_ready;
    logic [MSG_W-1:0] ring_in_msg;
    logic             ring_out_valid;
    logic             ring_out_ready;
    logic [MSG_W-1:0] ring_out_msg;
    logic             inj_valid;
    logic             inj_ready;
    logic [ID_W-1:0]  inj_dst;
    logic [PT_W-1:0]  inj_fft_pt;
    logic             inj_type;
    logic             ej_valid;
    logic             ej_ready;
    logic [ID_W-1:0]  ej_src;
    logic [PT_W-1:0]  ej_fft_pt;
    logic             ej_type;
    logic             err_drop;
    logic             mdest_done;

    modport slave (
        input  ring_in_valid, ring_in_msg, ring_out_ready,
        input  inj_valid, inj_dst, inj_fft_pt, inj_type, ej_ready,
        output ring_in_ready, ring_out_valid, ring_out_msg, inj_ready,
        output ej_valid, ej_src, ej_fft_pt, ej_type, err_drop, mdest_done
    );

    modport master (
        output ring_in_valid, ring_in_msg, ring_out_ready,
        output inj_valid, inj_dst, inj_fft_pt, inj_type, ej_ready,
        input  ring_in_ready, ring_out_valid, ring_out_msg, inj_ready,
        input  ej_valid, ej_src, ej_fft_pt, ej_type, err_drop, mdest_done
    );
endinterface

// File: rtl/fft_ring_node.sv
// FFT ring stop: classifies upstream messages (eject / forward / absorb / drop),
// injects local traffic from a small FIFO with starvation-forced slots.
module fft_ring_node #(
    parameter int NUM_NODES    = 8,
    parameter int NODE_ID      = 0,
    parameter int ID_W         = 8,
    parameter int PT_W         = 32,
    parameter int INJ_DEPTH    = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic           clk,
    input  logic           rst,
    fft_ring_node_if.slave bus
);
    localparam int HOP_W  = $clog2(NUM_NODES + 1);
    localparam int MSG_W  = 2 * ID_W + PT_W + 1 + HOP_W;
    localparam int PTR_W  = $clog2(INJ_DEPTH);
    localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
    localparam int FIFO_W = ID_W + PT_W + 1;
    localparam logic [ID_W-1:0]  MY_ID     = ID_W'(NODE_ID);
    localparam logic [HOP_W-1:0] HOP_MAX   = HOP_W'(NUM_NODES);
    localparam logic [CNT_W-1:0] STARVE_TC = CNT_W'(STARVE_LIMIT);

    logic [ID_W-1:0]  in_src, in_dst;
    logic [PT_W-1:0]  in_pt;
    logic             in_type;
    logic [HOP_W-1:0] in_hop, hop_inc;

    logic act_eject, act_absorb, act_ejfwd, act_drop, act_fwd;
    logic ro_can, ej_can, forced, slots_ok, in_ready, in_fire, claim_fire;

    logic [FIFO_W-1:0] fifo_mem [INJ_DEPTH];
    logic [PTR_W:0]    wr_ptr, rd_ptr;
    logic              fifo_empty, fifo_full, push, inj_fire;
    logic [ID_W-1:0]   h_dst;
    logic [PT_W-1:0]   h_pt;
    logic              h_type;
    logic [MSG_W-1:0]  inj_msg;
    logic [CNT_W-1:0]  starve_cnt;

    logic             ro_valid, ej_valid_q, ej_type_q, drop_q, done_q;
    logic [MSG_W-1:0] ro_msg;
    logic [ID_W-1:0]  ej_src_q;
    logic [PT_W-1:0]  ej_pt_q;

    assign {in_src, in_dst, in_pt, in_type, in_hop} = bus.ring_in_msg;
    assign hop_inc = (in_hop >= HOP_MAX) ? HOP_MAX : in_hop + HOP_W'(1);

    always_comb begin
        act_eject  = !in_type && (in_dst == MY_ID);
        act_absorb =  in_type && (in_src == MY_ID);
        act_ejfwd  =  in_type && (in_src != MY_ID);
        act_drop   = !in_type && (in_dst != MY_ID) && (in_hop >= HOP_MAX);
        act_fwd    = !in_type && (in_dst != MY_ID) && (in_hop <  HOP_MAX);
    end

    assign ro_can   = !ro_valid   || bus.ring_out_ready;
    assign ej_can   = !ej_valid_q || bus.ej_ready;
    assign forced   = (starve_cnt == STARVE_TC);
    assign slots_ok = (act_eject && ej_can) || act_absorb || act_drop
                    || (act_ejfwd && ej_can && ro_can) || (act_fwd && ro_can);
    assign in_ready   = slots_ok && !forced;
    assign in_fire    = bus.ring_in_valid && in_ready;
    assign claim_fire = in_fire && (act_fwd || act_ejfwd);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W])
                     && (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign push       = bus.inj_valid && !fifo_full && !rst;
    assign inj_fire   = !fifo_empty && ro_can && !claim_fire;

    assign {h_dst, h_pt, h_type} = fifo_mem[rd_ptr[PTR_W-1:0]];
    assign inj_msg = {MY_ID, (h_type ? MY_ID : h_dst), h_pt, h_type, HOP_W'(1)};

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= {bus.inj_dst, bus.inj_fft_pt, bus.inj_type};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            starve_cnt <= '0;
            ro_valid   <= 1'b0;
            ro_msg     <= '0;
            ej_valid_q <= 1'b0;
            ej_src_q   <= '0;
            ej_pt_q    <= '0;
            ej_type_q  <= 1'b0;
            drop_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            if (push)     wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
            if (inj_fire) rd_ptr <= rd_ptr + (PTR_W + 1)'(1);

            if (inj_fire)
                starve_cnt <= '0;
            else if (!fifo_empty && claim_fire && !forced)
                starve_cnt <= starve_cnt + CNT_W'(1);

            if (claim_fire) begin
                ro_valid <= 1'b1;
                ro_msg   <= {in_src, in_dst, in_pt, in_type, hop_inc};
            end else if (inj_fire) begin
                ro_valid <= 1'b1;
                ro_msg   <= inj_msg;
            end else if (bus.ring_out_ready) begin
                ro_valid <= 1'b0;
            end

            if (in_fire && (act_eject || act_ejfwd)) begin
                ej_valid_q <= 1'b1;
                ej_src_q   <= in_src;
                ej_pt_q    <= in_pt;
                ej_type_q  <= in_type;
            end else if (bus.ej_ready) begin
                ej_valid_q <= 1'b0;
            end

            drop_q <= in_fire && act_drop;
            done_q <= in_fire && act_absorb;
        end
    end

    assign bus.ring_in_ready  = in_ready;
    assign bus.ring_out_valid = ro_valid;
    assign bus.ring_out_msg   = ro_msg;
    assign bus.inj_ready      = !fifo_full && !rst;
    assign bus.ej_valid       = ej_valid_q;
    assign bus.ej_src         = ej_src_q;
    assign bus.ej_fft_pt      = ej_pt_q;
    assign bus.ej_type        = ej_type_q;
    assign bus.err_drop       = drop_q;
    assign bus.mdest_done     = done_q;
endmodule

// File: tb/tb_fft_ring_node.sv
// Bench for fft_ring_node (4-node ring, node 1): vector table plus stall,
// starvation and reset sequences, checked through output scoreboards.
module tb_fft_ring_node;
    localparam int NN    = 4;
    localparam int NID   = 1;
    localparam int ID_W  = 8;
    localparam int PT_W  = 32;
    localparam int SLIM  = 8;
    localparam int HOP_W = $clog2(NN + 1);
    localparam int MSG_W = 2 * ID_W + PT_W + 1 + HOP_W;

    typedef logic [MSG_W-1:0]     msg_t;
    typedef logic [ID_W+PT_W:0]   ejrec_t;
    typedef enum int {A_EJ, A_FW, A_EF, A_AB, A_DR} act_e;
    typedef struct {
        logic [ID_W-1:0]  src;
        logic [ID_W-1:0]  dst;
        logic [PT_W-1:0]  pt;
        logic             typ;
        logic [HOP_W-1:0] hop;
        act_e             act;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fft_ring_node_if #(.ID_W(ID_W), .PT_W(PT_W), .NUM_NODES(NN)) bus ();

    fft_ring_node #(
        .NUM_NODES(NN), .NODE_ID(NID), .ID_W(ID_W), .PT_W(PT_W),
        .INJ_DEPTH(4), .STARVE_LIMIT(SLIM)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int n_vec  = 0;
    int n_miss = 0;
    msg_t   exp_ro[$];
    ejrec_t exp_ej[$];
    int drop_seen = 0, done_seen = 0, exp_drop = 0, exp_done = 0;
    vec_t tbl[10];

    function automatic msg_t mk(input logic [ID_W-1:0] s, input logic [ID_W-1:0] d,
                                input logic [PT_W-1:0] p, input logic t,
                                input logic [HOP_W-1:0] h);
        return {s, d, p, t, h};
    endfunction

    function automatic logic [HOP_W-1:0] hop_next(input logic [HOP_W-1:0] h);
        return (h >= HOP_W'(NN)) ? HOP_W'(NN) : h + HOP_W'(1);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ring_out_valid && bus.ring_out_ready) begin
                if (exp_ro.size() == 0) begin
                    n_vec++; n_miss++;
                    $display("FAIL ro_unexpected: got msg %0h, required none", bus.ring_out_msg);
                end else check("ro_msg", 64'(bus.ring_out_msg), 64'(exp_ro.pop_front()));
            end
            if (bus.ej_valid && bus.ej_ready) begin
                if (exp_ej.size() == 0) begin
                    n_vec++; n_miss++;
                    $display("FAIL ej_unexpected: got src %0h pt %0h, required none",
                             bus.ej_src, bus.ej_fft_pt);
                end else check("ej_rec", 64'({bus.ej_src, bus.ej_fft_pt, bus.ej_type}),
                               64'(exp_ej.pop_front()));
            end
            if (bus.err_drop)   drop_seen++;
            if (bus.mdest_done) done_seen++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input msg_t m);
        bit ok = 1'b0;
        bus.ring_in_valid = 1'b1;
        bus.ring_in_msg   = m;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.ring_in_ready) begin ok = 1'b1; break; end
        end
        check("send_accept", 64'(ok), 64'd1);
        @(posedge clk); #1;
        bus.ring_in_valid = 1'b0;
    endtask

    task automatic push_exp(input vec_t v);
        case (v.act)
            A_EJ: exp_ej.push_back({v.src, v.pt, v.typ});
            A_FW: exp_ro.push_back(mk(v.src, v.dst, v.pt, v.typ, hop_next(v.hop)));
            A_EF: begin
                exp_ej.push_back({v.src, v.pt, v.typ});
                exp_ro.push_back(mk(v.src, v.dst, v.pt, v.typ, hop_next(v.hop)));
            end
            A_AB: exp_done++;
            default: exp_drop++;
        endcase
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_ro_left"}, 64'(exp_ro.size()), 64'd0);
        check({tag, "_ej_left"}, 64'(exp_ej.size()), 64'd0);
        check({tag, "_drops"},   64'(drop_seen), 64'(exp_drop));
        check({tag, "_dones"},   64'(done_seen), 64'(exp_done));
    endtask

    task automatic inject(input logic [ID_W-1:0] d, input logic [PT_W-1:0] p, input logic t);
        exp_ro.push_back(mk(ID_W'(NID), t ? ID_W'(NID) : d, p, t, HOP_W'(1)));
        bus.inj_dst = d; bus.inj_fft_pt = p; bus.inj_type = t; bus.inj_valid = 1'b1;
        @(negedge clk);
        check("inj_ready", 64'(bus.inj_ready), 64'd1);
        @(posedge clk); #1;
        bus.inj_valid = 1'b0;
        idle(3);
        check_drained("inj");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [PT_W-1:0] pt_s;
        msg_t inj_exp;
        bit   exp_rdy;

        tbl[0] = '{8'd0, 8'd1, 32'h1234, 1'b0, 3'd1, A_EJ};
        tbl[1] = '{8'd0, 8'd3, 32'h5678, 1'b0, 3'd1, A_FW};
        tbl[2] = '{8'd2, 8'd0, 32'h9abc, 1'b0, 3'd3, A_FW};
        tbl[3] = '{8'd3, 8'd2, 32'h1111, 1'b0, 3'd4, A_DR};
        tbl[4] = '{8'd0, 8'd7, 32'h2222, 1'b0, 3'd4, A_DR};
        tbl[5] = '{8'd0, 8'd7, 32'h3333, 1'b0, 3'd2, A_FW};
        tbl[6] = '{8'd2, 8'd0, 32'h4444, 1'b1, 3'd3, A_EF};
        tbl[7] = '{8'd1, 8'd1, 32'h5555, 1'b1, 3'd4, A_AB};
        tbl[8] = '{8'd3, 8'd3, 32'h6666, 1'b1, 3'd4, A_EF};
        tbl[9] = '{8'd1, 8'd1, 32'h7777, 1'b0, 3'd4, A_EJ};

        rst = 1'b1;
        bus.ring_in_valid = 1'b0; bus.ring_in_msg = '0;
        bus.ring_out_ready = 1'b1; bus.ej_ready = 1'b1;
        bus.inj_valid = 1'b0; bus.inj_dst = '0; bus.inj_fft_pt = '0; bus.inj_type = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ro_valid", 64'(bus.ring_out_valid), 64'd0);
        check("rst_ej_valid", 64'(bus.ej_valid), 64'd0);
        check("rst_err_drop", 64'(bus.err_drop), 64'd0);
        check("rst_mdest_done", 64'(bus.mdest_done), 64'd0);
        check("rst_inj_ready", 64'(bus.inj_ready), 64'd0);
        check("rst_ro_msg", 64'(bus.ring_out_msg), 64'd0);
        check("rst_ej_data", 64'({bus.ej_src, bus.ej_fft_pt}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_inj_ready", 64'(bus.inj_ready), 64'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            push_exp(tbl[i]);
            send(mk(tbl[i].src, tbl[i].dst, tbl[i].pt, tbl[i].typ, tbl[i].hop));
            idle(3);
            check_drained($sformatf("vec%0d", i));
        end

        // ej slot held full: forwarding proceeds, MDEST copy waits for both slots
        bus.ej_ready = 1'b0;
        exp_ej.push_back({8'd0, 32'haaaa, 1'b0});
        send(mk(8'd0, 8'd1, 32'haaaa, 1'b0, 3'd2));
        exp_ro.push_back(mk(8'd2, 8'd3, 32'hbbbb, 1'b0, 3'd2));
        send(mk(8'd2, 8'd3, 32'hbbbb, 1'b0, 3'd1));
        exp_ej.push_back({8'd2, 32'hcccc, 1'b1});
        exp_ro.push_back(mk(8'd2, 8'd2, 32'hcccc, 1'b1, 3'd4));
        bus.ring_in_valid = 1'b1;
        bus.ring_in_msg   = mk(8'd2, 8'd2, 32'hcccc, 1'b1, 3'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ef_stall_ready", 64'(bus.ring_in_ready), 64'd0);
        end
        @(posedge clk); #1;
        bus.ej_ready = 1'b1;
        @(negedge clk);
        check("ef_release_ready", 64'(bus.ring_in_ready), 64'd1);
        @(posedge clk); #1;
        bus.ring_in_valid = 1'b0;
        @(negedge clk);
        check("ef_both_valid", 64'({bus.ring_out_valid, bus.ej_valid}), 64'd3);
        idle(3);
        check_drained("ef");

        // continuous forwarding with one queued injection: forced slot after SLIM blocked cycles
        pt_s    = 32'h100;
        inj_exp = mk(ID_W'(NID), 8'd3, 32'habcd, 1'b0, 3'd1);
        bus.ring_in_valid = 1'b1;
        bus.ring_in_msg   = mk(8'd0, 8'd3, pt_s, 1'b0, 3'd1);
        bus.inj_dst = 8'd3; bus.inj_fft_pt = 32'habcd; bus.inj_type = 1'b0;
        bus.inj_valid = 1'b1;
        for (int c = 0; c < 16; c++) begin
            exp_rdy = (c != SLIM + 1);
            @(negedge clk);
            check($sformatf("starve_ready_c%0d", c), 64'(bus.ring_in_ready), 64'(exp_rdy));
            if (exp_rdy) exp_ro.push_back(mk(8'd0, 8'd3, pt_s, 1'b0, 3'd2));
            else         exp_ro.push_back(inj_exp);
            @(posedge clk); #1;
            bus.inj_valid = 1'b0;
            if (exp_rdy) begin
                pt_s = pt_s + 32'd1;
                bus.ring_in_msg = mk(8'd0, 8'd3, pt_s, 1'b0, 3'd1);
            end
        end
        bus.ring_in_valid = 1'b0;
        idle(3);
        check_drained("starve");

        inject(8'd1, 32'h5e1f, 1'b0);
        inject(8'd2, 32'h0055, 1'b1);
        inject(8'd0, 32'hd00d, 1'b0);

        // fill the FIFO behind a stalled ring_out slot, then reset mid-stream
        bus.ring_out_ready = 1'b0;
        exp_ro.push_back(mk(8'd0, 8'd2, 32'hf00d, 1'b0, 3'd2));
        send(mk(8'd0, 8'd2, 32'hf00d, 1'b0, 3'd1));
        for (int i = 0; i < 4; i++) begin
            bus.inj_dst = 8'd2; bus.inj_fft_pt = PT_W'(i); bus.inj_type = 1'b0;
            bus.inj_valid = 1'b1;
            @(negedge clk);
            check($sformatf("fill_ready%0d", i), 64'(bus.inj_ready), 64'd1);
            @(posedge clk); #1;
        end
        bus.inj_valid = 1'b0;
        @(negedge clk);
        check("fifo_full_ready", 64'(bus.inj_ready), 64'd0);
        check("fifo_full_ro_valid", 64'(bus.ring_out_valid), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_ro.delete();
        exp_ej.delete();
        @(posedge clk); #1;
        check("midrst_valids", 64'({bus.ring_out_valid, bus.ej_valid}), 64'd0);
        check("midrst_inj_ready", 64'(bus.inj_ready), 64'd0);
        rst = 1'b0;
        bus.ring_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_quiet", 64'(bus.ring_out_valid), 64'd0);
            check("post_rst_fifo_empty", 64'(bus.inj_ready), 64'd1);
        end
        check("final_drops", 64'(drop_seen), 64'(exp_drop));
        check("final_dones", 64'(done_seen), 64'(exp_done));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
